// File: rtl/id_decode_datapath_if.sv
`default_nettype none
// ============================================================================
// Module      : id_decode_datapath_if
// Description : Decode-stage bus bundle: instruction fields, WB traffic, outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface id_decode_datapath_if;
    logic        stall_flag;
    logic [4:0]  inst_read_reg_addr1;
    logic [4:0]  inst_read_reg_addr2;
    logic [4:0]  rd;
    logic        reg_dst;
    logic [15:0] inst_imm_field;
    logic        reg_write;
    logic [4:0]  reg_wr_addr_wb;
    logic [31:0] reg_wr_data;
    logic [31:0] reg_file_rd_data1;
    logic [31:0] reg_file_rd_data2;
    logic [31:0] sgn_ext_imm;
    logic [31:0] imm_sgn_ext_lft_shft;
    logic [15:0] imm_field_wo_sgn_ext;
    logic [4:0]  rd_out_id;

    modport master (
        output stall_flag, inst_read_reg_addr1, inst_read_reg_addr2, rd, reg_dst,
               inst_imm_field, reg_write, reg_wr_addr_wb, reg_wr_data,
        input  reg_file_rd_data1, reg_file_rd_data2, sgn_ext_imm,
               imm_sgn_ext_lft_shft, imm_field_wo_sgn_ext, rd_out_id
    );

    modport slave (
        input  stall_flag, inst_read_reg_addr1, inst_read_reg_addr2, rd, reg_dst,
               inst_imm_field, reg_write, reg_wr_addr_wb, reg_wr_data,
        output reg_file_rd_data1, reg_file_rd_data2, sgn_ext_imm,
               imm_sgn_ext_lft_shft, imm_field_wo_sgn_ext, rd_out_id
    );
endinterface
`default_nettype wire

// File: rtl/id_decode_datapath.sv
`default_nettype none
// ============================================================================
// Module      : id_decode_datapath
// Description : ID-stage register file with WB bypass, rt/rd select, immediate
//               extender, and stall shadow registers on every output.
// Revision    : 1.0 - initial release
// ============================================================================
module id_decode_datapath (
    input  logic                 clk,
    input  logic                 reset,
    id_decode_datapath_if.slave  dp
);
    localparam int unsigned C_NUM_REGS = 32;

    logic [31:0] r_regs_q [C_NUM_REGS];
    logic [31:0] r_regs_d [C_NUM_REGS];

    logic        w_wr_en;
    logic [31:0] w_rd_data1;
    logic [31:0] w_rd_data2;
    logic [31:0] w_sgn_ext;
    logic [31:0] w_shft;
    logic [4:0]  w_rd_out;

    logic [31:0] r_rd_data1_q, r_rd_data1_d;
    logic [31:0] r_rd_data2_q, r_rd_data2_d;
    logic [31:0] r_sgn_ext_q,  r_sgn_ext_d;
    logic [31:0] r_shft_q,     r_shft_d;
    logic [15:0] r_raw_imm_q,  r_raw_imm_d;
    logic [4:0]  r_rd_out_q,   r_rd_out_d;

    // Excluding address 0 here keeps r0 permanently zero in the array.
    assign w_wr_en = dp.reg_write && (dp.reg_wr_addr_wb != 5'd0);

    always_comb begin
        r_regs_d = r_regs_q;
        if (w_wr_en) begin
            r_regs_d[dp.reg_wr_addr_wb] = dp.reg_wr_data;
        end
    end

    always_comb begin
        w_rd_data1 = r_regs_q[dp.inst_read_reg_addr1];
        if (dp.inst_read_reg_addr1 == 5'd0) begin
            w_rd_data1 = '0;
        end else if (w_wr_en && (dp.reg_wr_addr_wb == dp.inst_read_reg_addr1)) begin
            w_rd_data1 = dp.reg_wr_data;
        end

        w_rd_data2 = r_regs_q[dp.inst_read_reg_addr2];
        if (dp.inst_read_reg_addr2 == 5'd0) begin
            w_rd_data2 = '0;
        end else if (w_wr_en && (dp.reg_wr_addr_wb == dp.inst_read_reg_addr2)) begin
            w_rd_data2 = dp.reg_wr_data;
        end
    end

    assign w_sgn_ext = {{16{dp.inst_imm_field[15]}}, dp.inst_imm_field};
    assign w_shft    = {w_sgn_ext[29:0], 2'b00};
    assign w_rd_out  = dp.reg_dst ? dp.rd : dp.inst_read_reg_addr2;

    // Shadows track the live values only on non-stalled edges.
    always_comb begin
        r_rd_data1_d = r_rd_data1_q;
        r_rd_data2_d = r_rd_data2_q;
        r_sgn_ext_d  = r_sgn_ext_q;
        r_shft_d     = r_shft_q;
        r_raw_imm_d  = r_raw_imm_q;
        r_rd_out_d   = r_rd_out_q;
        if (!dp.stall_flag) begin
            r_rd_data1_d = w_rd_data1;
            r_rd_data2_d = w_rd_data2;
            r_sgn_ext_d  = w_sgn_ext;
            r_shft_d     = w_shft;
            r_raw_imm_d  = dp.inst_imm_field;
            r_rd_out_d   = w_rd_out;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_regs_q[i] <= '0;
            end
            r_rd_data1_q <= '0;
            r_rd_data2_q <= '0;
            r_sgn_ext_q  <= '0;
            r_shft_q     <= '0;
            r_raw_imm_q  <= '0;
            r_rd_out_q   <= '0;
        end else begin
            r_regs_q     <= r_regs_d;
            r_rd_data1_q <= r_rd_data1_d;
            r_rd_data2_q <= r_rd_data2_d;
            r_sgn_ext_q  <= r_sgn_ext_d;
            r_shft_q     <= r_shft_d;
            r_raw_imm_q  <= r_raw_imm_d;
            r_rd_out_q   <= r_rd_out_d;
        end
    end

    assign dp.reg_file_rd_data1    = dp.stall_flag ? r_rd_data1_q : w_rd_data1;
    assign dp.reg_file_rd_data2    = dp.stall_flag ? r_rd_data2_q : w_rd_data2;
    assign dp.sgn_ext_imm          = dp.stall_flag ? r_sgn_ext_q  : w_sgn_ext;
    assign dp.imm_sgn_ext_lft_shft = dp.stall_flag ? r_shft_q     : w_shft;
    assign dp.imm_field_wo_sgn_ext = dp.stall_flag ? r_raw_imm_q  : dp.inst_imm_field;
    assign dp.rd_out_id            = dp.stall_flag ? r_rd_out_q   : w_rd_out;
endmodule
`default_nettype wire

// File: tb/tb_id_decode_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_decode_datapath
// Description : Self-checking bench: directed vectors, stall/reset sequences,
//               and random traffic against a behavioural register-file model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_id_decode_datapath;
    logic clk = 1'b0;
    logic reset;

    id_decode_datapath_if dp_if();

    id_decode_datapath dut (
        .clk   (clk),
        .reset (reset),
        .dp    (dp_if.slave)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sext;
        logic [31:0] shft;
        logic [15:0] raw;
        logic [4:0]  dst;
    } outs_t;

    typedef struct {
        logic [15:0] imm;
        logic        reg_dst;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] exp_sext;
        logic [31:0] exp_shft;
        logic [4:0]  exp_dst;
    } vec_t;

    logic [31:0] model_regs [32];
    outs_t       model_shadow;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (dp_if.reg_write && dp_if.reg_wr_addr_wb == a) return dp_if.reg_wr_data;
        return model_regs[a];
    endfunction

    function automatic outs_t model_live();
        outs_t o;
        o.rd1  = model_read(dp_if.inst_read_reg_addr1);
        o.rd2  = model_read(dp_if.inst_read_reg_addr2);
        o.sext = 32'($signed(dp_if.inst_imm_field));
        o.shft = o.sext * 32'd4;
        o.raw  = dp_if.inst_imm_field;
        o.dst  = dp_if.reg_dst ? dp_if.rd : dp_if.inst_read_reg_addr2;
        return o;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        model_shadow = '{default: '0};
    endtask

    task automatic chk_all(input string tag);
        outs_t e;
        e = dp_if.stall_flag ? model_shadow : model_live();
        chk({tag, "_rd1"},  dp_if.reg_file_rd_data1,    e.rd1);
        chk({tag, "_rd2"},  dp_if.reg_file_rd_data2,    e.rd2);
        chk({tag, "_sext"}, dp_if.sgn_ext_imm,          e.sext);
        chk({tag, "_shft"}, dp_if.imm_sgn_ext_lft_shft, e.shft);
        chk({tag, "_raw"},  {16'd0, dp_if.imm_field_wo_sgn_ext}, {16'd0, e.raw});
        chk({tag, "_dst"},  {27'd0, dp_if.rd_out_id},   {27'd0, e.dst});
    endtask

    // Apply the model's view of the next rising edge, then advance to the falling edge.
    task automatic tick();
        if (!dp_if.stall_flag) model_shadow = model_live();
        if (dp_if.reg_write && dp_if.reg_wr_addr_wb != 5'd0)
            model_regs[dp_if.reg_wr_addr_wb] = dp_if.reg_wr_data;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_idle();
        dp_if.stall_flag          = 1'b0;
        dp_if.inst_read_reg_addr1 = 5'd0;
        dp_if.inst_read_reg_addr2 = 5'd0;
        dp_if.rd                  = 5'd0;
        dp_if.reg_dst             = 1'b0;
        dp_if.inst_imm_field      = 16'd0;
        dp_if.reg_write           = 1'b0;
        dp_if.reg_wr_addr_wb      = 5'd0;
        dp_if.reg_wr_data         = 32'd0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs [6];
        vecs[0] = '{16'h8004, 1'b0, 5'd3,  5'd17, 32'hFFFF8004, 32'hFFFE0010, 5'd3};
        vecs[1] = '{16'h7FFF, 1'b1, 5'd3,  5'd17, 32'h00007FFF, 32'h0001FFFC, 5'd17};
        vecs[2] = '{16'h0000, 1'b0, 5'd31, 5'd0,  32'h00000000, 32'h00000000, 5'd31};
        vecs[3] = '{16'hFFFF, 1'b1, 5'd0,  5'd22, 32'hFFFFFFFF, 32'hFFFFFFFC, 5'd22};
        vecs[4] = '{16'h4000, 1'b0, 5'd8,  5'd9,  32'h00004000, 32'h00010000, 5'd8};
        vecs[5] = '{16'hC000, 1'b1, 5'd5,  5'd30, 32'hFFFFC000, 32'hFFFF0000, 5'd30};

        // Reset state
        reset = 1'b0;
        set_idle();
        model_clear();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_rd1",  dp_if.reg_file_rd_data1, 32'd0);
        chk("rst_rd2",  dp_if.reg_file_rd_data2, 32'd0);
        chk("rst_sext", dp_if.sgn_ext_imm, 32'd0);
        chk("rst_shft", dp_if.imm_sgn_ext_lft_shft, 32'd0);
        chk("rst_raw",  {16'd0, dp_if.imm_field_wo_sgn_ext}, 32'd0);
        chk("rst_dst",  {27'd0, dp_if.rd_out_id}, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // Back-to-back writes, then read both
        dp_if.reg_write = 1'b1; dp_if.reg_wr_addr_wb = 5'd5; dp_if.reg_wr_data = 32'hDEADBEEF;
        tick();
        dp_if.reg_wr_addr_wb = 5'd6; dp_if.reg_wr_data = 32'h12345678;
        tick();
        dp_if.reg_write = 1'b0;
        dp_if.inst_read_reg_addr1 = 5'd5; dp_if.inst_read_reg_addr2 = 5'd6;
        #1;
        chk("r5_read", dp_if.reg_file_rd_data1, 32'hDEADBEEF);
        chk("r6_read", dp_if.reg_file_rd_data2, 32'h12345678);

        // r0 is hard-wired to zero, bypass included
        dp_if.reg_write = 1'b1; dp_if.reg_wr_addr_wb = 5'd0; dp_if.reg_wr_data = 32'hFFFFFFFF;
        dp_if.inst_read_reg_addr1 = 5'd0;
        #1;
        chk("r0_bypass", dp_if.reg_file_rd_data1, 32'd0);
        tick();
        dp_if.reg_write = 1'b0;
        #1;
        chk("r0_stored", dp_if.reg_file_rd_data1, 32'd0);

        // Same-cycle WB->ID bypass, then array holds it
        dp_if.reg_write = 1'b1; dp_if.reg_wr_addr_wb = 5'd9; dp_if.reg_wr_data = 32'hA5A5A5A5;
        dp_if.inst_read_reg_addr1 = 5'd9;
        #1;
        chk("r9_bypass", dp_if.reg_file_rd_data1, 32'hA5A5A5A5);
        tick();
        dp_if.reg_write = 1'b0;
        #1;
        chk("r9_stored", dp_if.reg_file_rd_data1, 32'hA5A5A5A5);

        // Extender / destination-mux vectors
        for (int i = 0; i < 6; i++) begin
            dp_if.inst_imm_field = vecs[i].imm;
            dp_if.reg_dst = vecs[i].reg_dst;
            dp_if.inst_read_reg_addr2 = vecs[i].rt;
            dp_if.rd = vecs[i].rd;
            #1;
            chk($sformatf("vec%0d_sext", i), dp_if.sgn_ext_imm, vecs[i].exp_sext);
            chk($sformatf("vec%0d_shft", i), dp_if.imm_sgn_ext_lft_shft, vecs[i].exp_shft);
            chk($sformatf("vec%0d_raw", i), {16'd0, dp_if.imm_field_wo_sgn_ext}, {16'd0, vecs[i].imm});
            chk($sformatf("vec%0d_dst", i), {27'd0, dp_if.rd_out_id}, {27'd0, vecs[i].exp_dst});
            tick();
        end

        // Stall hold across a write to the register being read
        dp_if.inst_read_reg_addr1 = 5'd5;
        dp_if.inst_imm_field = 16'h0010; dp_if.reg_dst = 1'b1; dp_if.rd = 5'd17;
        tick();
        dp_if.stall_flag = 1'b1;
        dp_if.inst_imm_field = 16'hFFFF; dp_if.rd = 5'd4;
        dp_if.reg_write = 1'b1; dp_if.reg_wr_addr_wb = 5'd5; dp_if.reg_wr_data = 32'h0BADF00D;
        #1;
        chk("stall_sext", dp_if.sgn_ext_imm, 32'h00000010);
        chk("stall_shft", dp_if.imm_sgn_ext_lft_shft, 32'h00000040);
        chk("stall_dst",  {27'd0, dp_if.rd_out_id}, 32'd17);
        chk("stall_rd1",  dp_if.reg_file_rd_data1, 32'hDEADBEEF);
        tick();
        dp_if.reg_write = 1'b0;
        tick();
        tick();
        #1;
        chk("stall_long_sext", dp_if.sgn_ext_imm, 32'h00000010);
        chk("stall_long_raw",  {16'd0, dp_if.imm_field_wo_sgn_ext}, 32'h00000010);
        chk("stall_long_rd1",  dp_if.reg_file_rd_data1, 32'hDEADBEEF);
        dp_if.stall_flag = 1'b0;
        #1;
        chk("release_sext", dp_if.sgn_ext_imm, 32'hFFFFFFFF);
        chk("release_shft", dp_if.imm_sgn_ext_lft_shft, 32'hFFFFFFFC);
        chk("release_dst",  {27'd0, dp_if.rd_out_id}, 32'd4);
        chk("release_rd1",  dp_if.reg_file_rd_data1, 32'h0BADF00D);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            dp_if.stall_flag          = ($urandom_range(0, 3) == 0);
            dp_if.inst_read_reg_addr1 = 5'($urandom_range(0, 7));
            dp_if.inst_read_reg_addr2 = 5'($urandom_range(0, 7));
            dp_if.rd                  = 5'($urandom_range(0, 31));
            dp_if.reg_dst             = 1'($urandom_range(0, 1));
            dp_if.inst_imm_field      = 16'($urandom);
            dp_if.reg_write           = 1'($urandom_range(0, 1));
            dp_if.reg_wr_addr_wb      = 5'($urandom_range(0, 7));
            dp_if.reg_wr_data         = $urandom;
            #1;
            chk_all($sformatf("rnd%0d", n));
            tick();
        end

        // Asynchronous reset mid-operation beats a concurrent write and clears shadows
        dp_if.stall_flag = 1'b1;
        dp_if.inst_imm_field = 16'h1234;
        dp_if.reg_write = 1'b1; dp_if.reg_wr_addr_wb = 5'd7; dp_if.reg_wr_data = 32'h77777777;
        reset = 1'b0;
        #1;
        chk("arst_shadow_sext", dp_if.sgn_ext_imm, 32'd0);
        chk("arst_shadow_rd1",  dp_if.reg_file_rd_data1, 32'd0);
        @(posedge clk);
        @(negedge clk);
        model_clear();
        dp_if.reg_write = 1'b0;
        dp_if.stall_flag = 1'b0;
        reset = 1'b1;
        dp_if.inst_read_reg_addr1 = 5'd7;
        dp_if.inst_read_reg_addr2 = 5'd5;
        #1;
        chk("arst_r7", dp_if.reg_file_rd_data1, 32'd0);
        chk("arst_r5", dp_if.reg_file_rd_data2, 32'd0);
        chk_all("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
